// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester (fetch / LSU) arbiter in front of a single-ported
//               memory bus. One transaction outstanding at a time; LSU has
//               priority. An optional starvation guard forces fetch through
//               after STARVE_MAX consecutive contested LSU wins.
// Options     : define ARB_STARVE_GUARD_EN to enable the starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   // fetch requester
   input  logic                  i_if_req,
   input  logic [ADDR_W-1:0]     i_if_addr,
   output logic                  o_if_gnt,
   output logic                  o_if_rvalid,
   output logic [DATA_W-1:0]     o_if_rdata,
   // LSU requester
   input  logic                  i_lsu_req,
   input  logic                  i_lsu_we,
   input  logic [DATA_W/8-1:0]   i_lsu_be,
   input  logic [ADDR_W-1:0]     i_lsu_addr,
   input  logic [DATA_W-1:0]     i_lsu_wdata,
   output logic                  o_lsu_gnt,
   output logic                  o_lsu_done,
   output logic [DATA_W-1:0]     o_lsu_rdata,
   // downstream memory port
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [DATA_W/8-1:0]   o_mem_be,
   output logic [ADDR_W-1:0]     o_mem_addr,
   output logic [DATA_W-1:0]     o_mem_wdata,
   input  logic                  i_mem_ack,
   input  logic [DATA_W-1:0]     i_mem_rdata,
   output logic                  o_busy
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_BUSY_IF  = 2'd1,
      S_BUSY_LSU = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [DATA_W/8-1:0]   r_mem_be;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [DATA_W-1:0]     r_mem_wdata;
   logic [DATA_W-1:0]     r_if_rdata;
   logic [DATA_W-1:0]     r_lsu_rdata;
   logic                  r_if_rvalid;
   logic                  r_lsu_done;

   logic                  w_idle;
   logic                  w_force_if;
   logic                  w_pick_lsu;
   logic                  w_pick_if;
   logic                  w_if_gnt;
   logic                  w_lsu_gnt;

   // LSU normally wins a contested cycle; the guard can hand it to fetch.
   assign w_idle     = (r_state == S_IDLE);
   assign w_pick_lsu = i_lsu_req & ~(i_if_req & w_force_if);
   assign w_pick_if  = i_if_req & ~w_pick_lsu;
   // Grants are suppressed during reset so nothing is accepted on that edge.
   assign w_lsu_gnt  = i_rstn & w_idle & w_pick_lsu;
   assign w_if_gnt   = i_rstn & w_idle & w_pick_if;

`ifdef ARB_STARVE_GUARD_EN
   localparam int                 c_CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_MAX);

   logic [c_CNT_W-1:0] r_starve;

   assign w_force_if = (r_starve == c_CNT_MAX);

   // Count contested LSU wins; any fetch grant or fetch-idle cycle clears it.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_starve <= '0;
      end else if (w_idle) begin
         if (w_if_gnt || !i_if_req) begin
            r_starve <= '0;
         end else if (w_lsu_gnt && (r_starve != c_CNT_MAX)) begin
            r_starve <= r_starve + 1'b1;
         end
      end
   end
`else
   logic w_unused_starve;

   assign w_force_if      = 1'b0;
   assign w_unused_starve = (STARVE_MAX != 0);
`endif

   // Transaction FSM: accept in IDLE, hold the bus until ack, return result.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state     <= S_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_lsu_rdata <= '0;
         r_if_rvalid <= 1'b0;
         r_lsu_done  <= 1'b0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_lsu_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_lsu_gnt) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= i_lsu_we;
                  r_mem_be    <= i_lsu_be;
                  r_mem_addr  <= i_lsu_addr;
                  r_mem_wdata <= i_lsu_wdata;
                  r_state     <= S_BUSY_LSU;
               end else if (w_if_gnt) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_be    <= '1;
                  r_mem_addr  <= i_if_addr;
                  r_mem_wdata <= '0;
                  r_state     <= S_BUSY_IF;
               end
            end
            S_BUSY_IF: begin
               if (i_mem_ack) begin
                  r_if_rdata  <= i_mem_rdata;
                  r_if_rvalid <= 1'b1;
                  r_mem_req   <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            S_BUSY_LSU: begin
               if (i_mem_ack) begin
                  // Stores leave the load-data register untouched.
                  if (!r_mem_we) begin
                     r_lsu_rdata <= i_mem_rdata;
                  end
                  r_lsu_done <= 1'b1;
                  r_mem_req  <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign o_if_gnt    = w_if_gnt;
   assign o_lsu_gnt   = w_lsu_gnt;
   assign o_if_rvalid = r_if_rvalid;
   assign o_if_rdata  = r_if_rdata;
   assign o_lsu_done  = r_lsu_done;
   assign o_lsu_rdata = r_lsu_rdata;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_be    = r_mem_be;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_busy      = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               followed by randomized requesters and a random-latency memory,
//               all compared against a transaction-level reference model.
// Options     : honours ARB_STARVE_GUARD_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int c_AW = 32;
   localparam int c_DW = 32;
   localparam int c_SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit c_GUARD = 1'b1;
`else
   localparam bit c_GUARD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rstn;
   logic              if_req, lsu_req, lsu_we, mem_ack;
   logic [c_AW-1:0]   if_addr, lsu_addr;
   logic [3:0]        lsu_be;
   logic [c_DW-1:0]   lsu_wdata, mem_rdata;
   logic              o_if_gnt, o_if_rvalid, o_lsu_gnt, o_lsu_done;
   logic              o_mem_req, o_mem_we, o_busy;
   logic [c_DW-1:0]   o_if_rdata, o_lsu_rdata, o_mem_wdata;
   logic [3:0]        o_mem_be;
   logic [c_AW-1:0]   o_mem_addr;

   mem_port_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .STARVE_MAX(c_SMAX)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(o_if_gnt),
      .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
      .i_lsu_req(lsu_req), .i_lsu_we(lsu_we), .i_lsu_be(lsu_be),
      .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata), .o_lsu_gnt(o_lsu_gnt),
      .o_lsu_done(o_lsu_done), .o_lsu_rdata(o_lsu_rdata),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, what the requesters should see.
   int              m_owner = 0;     // 0 none, 1 fetch, 2 lsu
   int              m_cnt   = 0;     // contested LSU wins in a row
   int              m_lat   = 0;     // memory agent countdown
   bit              m_just_rst = 0;
   bit              p_if = 0, p_lsu = 0;  // model grants this cycle
   logic            s_if_gnt, s_lsu_gnt;  // DUT grants this cycle
   logic            e_mem_req = 0, e_we = 0, e_if_rv = 0, e_lsu_dn = 0;
   logic [3:0]      e_be = 0;
   logic [c_AW-1:0] e_addr = 0;
   logic [c_DW-1:0] e_wdata = 0, e_if_rdata = 0, e_lsu_rdata = 0;
   bit              e_wdata_chk = 1;

   task automatic model_step();
      if (!rstn) begin
         m_owner = 0; m_cnt = 0; m_just_rst = 1;
         e_mem_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
         e_if_rdata = 0; e_lsu_rdata = 0; e_if_rv = 0; e_lsu_dn = 0;
         e_wdata_chk = 1;
         return;
      end
      m_just_rst = 0;
      e_if_rv = 0; e_lsu_dn = 0;
      if (m_owner == 0) begin
         if (p_if || !if_req)  m_cnt = 0;
         else if (p_lsu)       m_cnt = (m_cnt < c_SMAX) ? m_cnt + 1 : c_SMAX;
         if (p_lsu) begin
            m_owner = 2; e_mem_req = 1; e_we = lsu_we; e_be = lsu_be;
            e_addr = lsu_addr; e_wdata = lsu_wdata; e_wdata_chk = 1;
            m_lat = $urandom_range(0, 4);
         end else if (p_if) begin
            m_owner = 1; e_mem_req = 1; e_we = 0; e_be = 4'hF;
            e_addr = if_addr; e_wdata_chk = 0;
            m_lat = $urandom_range(0, 4);
         end
      end else if (mem_ack) begin
         if (m_owner == 1) begin
            e_if_rdata = mem_rdata; e_if_rv = 1;
         end else begin
            if (!e_we) e_lsu_rdata = mem_rdata;
            e_lsu_dn = 1;
         end
         m_owner = 0; e_mem_req = 0;
      end
   endtask

   // One clock: inputs already set; check grants, advance, check registers.
   task automatic cycle();
      bit force_if;
      #1;
      force_if = c_GUARD && (m_cnt == c_SMAX);
      p_lsu = rstn && (m_owner == 0) && lsu_req && !(if_req && force_if);
      p_if  = rstn && (m_owner == 0) && if_req && !p_lsu;
      s_if_gnt  = o_if_gnt;
      s_lsu_gnt = o_lsu_gnt;
      chk("if_gnt", s_if_gnt, p_if);
      chk("lsu_gnt", s_lsu_gnt, p_lsu);
      model_step();
      @(negedge clk);
      chk("mem_req", o_mem_req, e_mem_req);
      if (e_mem_req || m_just_rst) begin
         chk("mem_addr", o_mem_addr, e_addr);
         chk("mem_we", o_mem_we, e_we);
         chk("mem_be", o_mem_be, e_be);
         if (e_wdata_chk) chk("mem_wdata", o_mem_wdata, e_wdata);
      end
      chk("if_rvalid", o_if_rvalid, e_if_rv);
      chk("lsu_done", o_lsu_done, e_lsu_dn);
      chk("if_rdata", o_if_rdata, e_if_rdata);
      chk("lsu_rdata", o_lsu_rdata, e_lsu_rdata);
      chk("busy", o_busy, m_owner != 0);
   endtask

   initial begin
      int lat;
      int ngr;
      logic [31:0] tmp;
      rstn = 0; if_req = 0; if_addr = 0; lsu_req = 0; lsu_we = 0; lsu_be = 0;
      lsu_addr = 0; lsu_wdata = 0; mem_ack = 0; mem_rdata = 0;
      @(negedge clk);

      // Reset
      cycle(); cycle();
      rstn = 1;
      cycle();
      chk("rst_busy", o_busy, 0);

      // Single fetch, ack 3 cycles after o_mem_req
      if_req = 1; if_addr = 32'h100;
      cycle();
      chk("sf_gnt", s_if_gnt, 1);
      if_req = 0;
      chk("sf_addr", o_mem_addr, 32'h100);
      chk("sf_we", o_mem_we, 0);
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
         mem_ack = (c == 4);
         mem_rdata = (c == 4) ? 32'h00500093 : $urandom;
         cycle();
         if (o_if_rvalid && lat < 0) lat = c + 1;
      end
      mem_ack = 0;
      chk("sf_lat", lat, 5);
      chk("sf_rdata", o_if_rdata, 32'h00500093);

      // Contention: LSU load wins, fetch follows right after done
      if_req = 1; if_addr = 32'h200;
      lsu_req = 1; lsu_we = 0; lsu_be = 4'hF; lsu_addr = 32'h2000;
      cycle();
      chk("ct_lsu_gnt", s_lsu_gnt, 1);
      chk("ct_if_gnt0", s_if_gnt, 0);
      lsu_req = 0; mem_ack = 1; mem_rdata = 32'h12345678;
      cycle();
      chk("ct_done", o_lsu_done, 1);
      chk("ct_ldata", o_lsu_rdata, 32'h12345678);
      mem_ack = 0;
      cycle();
      chk("ct_if_gnt1", s_if_gnt, 1);
      if_req = 0; mem_ack = 1; mem_rdata = 32'hCAFE0001;
      cycle();
      mem_ack = 0;
      cycle();

      // Store with zero-cycle ack
      lsu_req = 1; lsu_we = 1; lsu_be = 4'b0011; lsu_wdata = 32'hDEADBEEF;
      lsu_addr = 32'h3004;
      cycle();
      chk("st_gnt", s_lsu_gnt, 1);
      lsu_req = 0;
      chk("st_we", o_mem_we, 1);
      chk("st_be", o_mem_be, 4'b0011);
      chk("st_wdata", o_mem_wdata, 32'hDEADBEEF);
      chk("st_addr", o_mem_addr, 32'h3004);
      mem_ack = 1; mem_rdata = 32'h55555555;
      cycle();
      mem_ack = 0;
      chk("st_done", o_lsu_done, 1);
      chk("st_rdata", o_lsu_rdata, 32'h12345678);

      // Spurious ack in IDLE
      mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
      cycle();
      mem_ack = 0;
      chk("sp_rv", o_if_rvalid, 0);
      chk("sp_done", o_lsu_done, 0);
      chk("sp_busy", o_busy, 0);
      chk("sp_if_rdata", o_if_rdata, 32'hCAFE0001);
      cycle();

      // Starvation: both requesting continuously, instant memory
      if_req = 1; if_addr = 32'h400; lsu_req = 1; lsu_we = 0; lsu_addr = 32'h5000;
      ngr = 0;
      for (int c = 0; c < 60 && ngr < 15; c++) begin
         mem_ack = (m_owner != 0);
         mem_rdata = $urandom;
         cycle();
         if (s_lsu_gnt || s_if_gnt) begin
            chk("starve_seq", s_if_gnt, c_GUARD && (ngr % 5 == 4));
            ngr++;
         end
      end
      chk("starve_cnt", ngr, 15);
      if_req = 0; lsu_req = 0;
      for (int c = 0; c < 3; c++) begin
         mem_ack = (m_owner != 0);
         cycle();
      end
      mem_ack = 0;

      // Reset while BUSY_LSU, then a late ack
      lsu_req = 1; lsu_we = 0; lsu_addr = 32'h6000;
      cycle();
      chk("rm_gnt", s_lsu_gnt, 1);
      lsu_req = 0; rstn = 0;
      cycle();
      chk("rm_req", o_mem_req, 0);
      chk("rm_busy", o_busy, 0);
      rstn = 1; mem_ack = 1; mem_rdata = 32'h77777777;
      cycle();
      chk("rm_done", o_lsu_done, 0);
      mem_ack = 0;
      cycle();
      chk("rm_done2", o_lsu_done, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if (!if_req || p_if) begin
            tmp = $urandom;
            if_req = ($urandom % 3) != 0;
            if_addr = tmp & ~32'h3;
         end
         if (!lsu_req || p_lsu) begin
            tmp = $urandom;
            lsu_req = ($urandom % 2) != 0;
            lsu_we = ($urandom % 2) != 0;
            lsu_be = 4'($urandom);
            lsu_addr = tmp & ~32'h3;
            lsu_wdata = $urandom;
         end
         rstn = ($urandom % 80) != 0;
         if (m_owner != 0) begin
            if (m_lat == 0) mem_ack = 1;
            else begin
               mem_ack = 0;
               m_lat--;
            end
         end else begin
            mem_ack = ($urandom % 8) == 0;
         end
         mem_rdata = $urandom;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
